// File: rtl/dcache_responder.sv
// Data-memory responder: accepts one request at a time, inserts WAIT_CYCLES idle
// cycles, strobes a 64-bit-word RAM and returns read data as a one-cycle pulse.
module dcache_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [63:0] cmd_payload_addr,
  input  logic        cmd_payload_wen,
  input  logic [63:0] cmd_payload_wdata,
  input  logic [7:0]  cmd_payload_wstrb,
  output logic        rsp_valid,
  output logic [63:0] rsp_payload_data,
  output logic        ram_en,
  output logic [27:0] ram_idx,
  output logic        ram_wen,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  input  logic [63:0] ram_rdata,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_READ, S_RESP} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q, rsp_valid_q, ram_en_q, ram_wen_q;
  logic [63:0] rsp_data_q, ram_wmask_q, wdata_q;
  logic [27:0] idx_q;
  logic        oor_q, wen_q;
  logic [7:0]  wstrb_q;
  logic [15:0] err_q;

  // Offset computed on the word part with an explicit borrow from the byte part.
  logic [60:0] in_off_hi;
  logic        in_oor, accept, go_access, a_oor, a_wen, a_fire;
  logic [7:0]  a_wstrb;
  logic [63:0] a_mask;

  assign in_off_hi = cmd_payload_addr[63:3] - BASE_ADDR[63:3]
                   - 61'(cmd_payload_addr[2:0] < BASE_ADDR[2:0]);
  assign in_oor    = (cmd_payload_addr < BASE_ADDR) || (in_off_hi[60:28] != '0);
  assign accept    = (state_q == S_IDLE) && ready_q && cmd_valid;
  assign go_access = (accept && (WAIT_CYCLES == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd0));

  // With no wait states the RAM strobe is set up straight from the live payload.
  assign a_oor   = accept ? in_oor            : oor_q;
  assign a_wen   = accept ? cmd_payload_wen   : wen_q;
  assign a_wstrb = accept ? cmd_payload_wstrb : wstrb_q;
  assign a_fire  = !a_oor && !(a_wen && (a_wstrb == 8'h00));

  always_comb begin
    a_mask = '0;
    for (int i = 0; i < 8; i++) a_mask[8*i +: 8] = {8{a_wstrb[i]}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      ram_en_q    <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_wmask_q <= '0;
      err_q       <= '0;
      idx_q       <= '0;
      oor_q       <= 1'b0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      ram_en_q    <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_wmask_q <= '0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!ready_q) begin
            ready_q <= 1'b1;
          end else if (cmd_valid) begin
            ready_q <= 1'b0;
            idx_q   <= in_off_hi[27:0];
            oor_q   <= in_oor;
            wen_q   <= cmd_payload_wen;
            wdata_q <= cmd_payload_wdata;
            wstrb_q <= cmd_payload_wstrb;
            if (WAIT_CYCLES > 0) begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_ACCESS;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_ACCESS: begin
          if (oor_q && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
          if (wen_q) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            state_q <= S_READ;
          end
        end
        S_READ: begin
          rsp_data_q  <= oor_q ? 64'h0 : ram_rdata;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
      if (go_access) begin
        ram_en_q    <= a_fire;
        ram_wen_q   <= a_fire && a_wen;
        ram_wmask_q <= (a_fire && a_wen) ? a_mask : 64'h0;
      end
    end
  end

  assign cmd_ready        = ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_payload_data = rsp_data_q;
  assign ram_en           = ram_en_q;
  assign ram_idx          = idx_q;
  assign ram_wen          = ram_wen_q;
  assign ram_wdata        = wdata_q;
  assign ram_wmask        = ram_wmask_q;
  assign err_count        = err_q;

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: two instances (2 and 0 wait states) share one
// stimulus stream; a transaction-level model predicts every output each cycle.
module tb_dcache_responder;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic clk, rst;
  logic cmd_valid, cmd_wen;
  logic [63:0] cmd_addr, cmd_wdata;
  logic [7:0]  cmd_wstrb;

  logic [1:0]  rdy, rv, en, wen;
  logic [63:0] rsp_d [2];
  logic [63:0] wdata [2];
  logic [63:0] wmask [2];
  logic [63:0] ram_rd [2];
  logic [27:0] idx [2];
  logic [15:0] err [2];

  int checks = 0, failures = 0;
  bit done = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  dcache_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(2)) u_w2 (
    .clock(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
    .cmd_payload_addr(cmd_addr), .cmd_payload_wen(cmd_wen),
    .cmd_payload_wdata(cmd_wdata), .cmd_payload_wstrb(cmd_wstrb),
    .rsp_valid(rv[0]), .rsp_payload_data(rsp_d[0]), .ram_en(en[0]),
    .ram_idx(idx[0]), .ram_wen(wen[0]), .ram_wdata(wdata[0]),
    .ram_wmask(wmask[0]), .ram_rdata(ram_rd[0]), .err_count(err[0]));

  dcache_responder #(.BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_w0 (
    .clock(clk), .reset(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
    .cmd_payload_addr(cmd_addr), .cmd_payload_wen(cmd_wen),
    .cmd_payload_wdata(cmd_wdata), .cmd_payload_wstrb(cmd_wstrb),
    .rsp_valid(rv[1]), .rsp_payload_data(rsp_d[1]), .ram_en(en[1]),
    .ram_idx(idx[1]), .ram_wen(wen[1]), .ram_wdata(wdata[1]),
    .ram_wmask(wmask[1]), .ram_rdata(ram_rd[1]), .err_count(err[1]));

  function automatic int wc(input int j);
    return (j == 0) ? 2 : 0;
  endfunction

  // RAM contents: word 2 holds DEAD_BEEF_0123_4567, other words differ in the top bits.
  function automatic logic [63:0] ram_val(input logic [27:0] i);
    return 64'hDEAD_BEEF_0123_4567 ^ {i ^ 28'd2, 36'd0};
  endfunction

  function automatic logic [63:0] expand(input logic [7:0] s);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{s[i]}};
    return r;
  endfunction

  function automatic logic f_oor(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return (a < BASE) || (off[63:31] != 0);
  endfunction

  function automatic logic [27:0] f_idx(input logic [63:0] a);
    logic [63:0] off;
    off = a - BASE;
    return off[30:3];
  endfunction

  always @(posedge clk) begin
    for (int j = 0; j < 2; j++)
      ram_rd[j] <= (en[j] && !wen[j]) ? ram_val(idx[j]) : {$urandom, $urandom};
  end

  // Model: per instance, one outstanding transaction and the number of edges since acceptance.
  bit          m_busy [2], m_rdy [2], m_wr [2], m_oor [2];
  int          m_k [2], m_err [2];
  logic [27:0] m_idx [2];
  logic [7:0]  m_ws [2];
  logic [63:0] m_wd [2], m_rsp [2];

  always @(posedge clk or posedge rst) begin
    for (int j = 0; j < 2; j++) begin
      if (rst) begin
        m_busy[j] <= 0; m_rdy[j] <= 0; m_err[j] <= 0; m_rsp[j] <= 0; m_k[j] <= 0;
      end else if (m_rdy[j] && cmd_valid) begin
        m_busy[j] <= 1; m_rdy[j] <= 0; m_k[j] <= 0;
        m_wr[j] <= cmd_wen; m_oor[j] <= f_oor(cmd_addr); m_idx[j] <= f_idx(cmd_addr);
        m_ws[j] <= cmd_wstrb; m_wd[j] <= cmd_wdata;
      end else if (m_busy[j]) begin
        m_k[j] <= m_k[j] + 1;
        if (m_k[j] + 1 == wc(j) + 1 && m_oor[j] && m_err[j] < 65535) m_err[j] <= m_err[j] + 1;
        if (m_wr[j] && m_k[j] + 1 == wc(j) + 1) begin m_busy[j] <= 0; m_rdy[j] <= 1; end
        if (!m_wr[j] && m_k[j] + 1 == wc(j) + 2) m_rsp[j] <= m_oor[j] ? 64'h0 : ram_val(m_idx[j]);
        if (!m_wr[j] && m_k[j] + 1 == wc(j) + 3) begin m_busy[j] <= 0; m_rdy[j] <= 1; end
      end else if (!m_rdy[j]) begin
        m_rdy[j] <= 1;
      end
    end
  end

  task automatic chk(input int j, input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%h required=%h", n, j, $time, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      for (int j = 0; j < 2; j++) begin
        logic ee, ew;
        ee = m_busy[j] && m_k[j] == wc(j) && !m_oor[j] && !(m_wr[j] && m_ws[j] == 8'h00);
        ew = ee && m_wr[j];
        chk(j, "cmd_ready", 64'(rdy[j]), 64'(m_rdy[j]));
        chk(j, "ram_en", 64'(en[j]), 64'(ee));
        chk(j, "ram_wen", 64'(wen[j]), 64'(ew));
        chk(j, "ram_wmask", wmask[j], ew ? expand(m_ws[j]) : 64'h0);
        if (ee) chk(j, "ram_idx", 64'(idx[j]), 64'(m_idx[j]));
        if (ew) chk(j, "ram_wdata", wdata[j], m_wd[j]);
        chk(j, "rsp_valid", 64'(rv[j]), 64'(m_busy[j] && !m_wr[j] && m_k[j] == wc(j) + 2));
        chk(j, "rsp_data", rsp_d[j], m_rsp[j]);
        chk(j, "err_count", 64'(err[j]), 64'(m_err[j]));
      end
    end
  end

  logic [8:1]  h_en [2], h_rv [2];
  logic [27:0] c_idx [2];
  logic [63:0] c_mask [2], c_data [2];
  logic        c_wen [2];

  task automatic wait_rdy();
    int n = 0;
    while (!(rdy[0] && rdy[1]) && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL wait_ready timeout actual=%b required=11", rdy);
    end
  endtask

  // Issue one request to both instances, then record 8 cycles of strobes/responses.
  task automatic txn(input logic [63:0] a, input logic w, input logic [63:0] d, input logic [7:0] s);
    wait_rdy();
    cmd_valid = 1; cmd_addr = a; cmd_wen = w; cmd_wdata = d; cmd_wstrb = s;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_addr = {$urandom, $urandom}; cmd_wen = ~w;
    cmd_wdata = {$urandom, $urandom}; cmd_wstrb = 8'($urandom);
    for (int j = 0; j < 2; j++) begin h_en[j] = '0; h_rv[j] = '0; end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        if (en[j]) begin h_en[j][c] = 1; c_idx[j] = idx[j]; c_mask[j] = wmask[j]; c_wen[j] = wen[j]; end
        if (rv[j]) begin h_rv[j][c] = 1; c_data[j] = rsp_d[j]; end
      end
    end
  endtask

  initial begin
    rst = 1; cmd_valid = 0; cmd_wen = 0; cmd_addr = BASE; cmd_wdata = 0; cmd_wstrb = 0;
    repeat (3) @(posedge clk);
    #1;
    chk(0, "reset_ready", 64'(rdy[0]), 64'h0);
    chk(0, "reset_err", 64'(err[0]), 64'h0);
    rst = 0;

    // Read, 2 wait states: strobe in cycle 3, response in cycle 5.
    txn(64'h8000_0010, 0, 64'h0, 8'hFF);
    chk(0, "rd_en_cycle", 64'(h_en[0]), 64'h04);
    chk(0, "rd_idx", 64'(c_idx[0]), 64'd2);
    chk(0, "rd_wen", 64'(c_wen[0]), 64'h0);
    chk(0, "rd_rsp_cycle", 64'(h_rv[0]), 64'h10);
    chk(0, "rd_data", c_data[0], 64'hDEAD_BEEF_0123_4567);
    chk(1, "rd_en_cycle", 64'(h_en[1]), 64'h01);
    chk(1, "rd_rsp_cycle", 64'(h_rv[1]), 64'h04);

    // Write, 0 wait states.
    txn(64'h8000_0008, 1, 64'h1122_3344_5566_7788, 8'h0F);
    chk(1, "wr_en_cycle", 64'(h_en[1]), 64'h01);
    chk(1, "wr_wen", 64'(c_wen[1]), 64'h1);
    chk(1, "wr_idx", 64'(c_idx[1]), 64'd1);
    chk(1, "wr_mask", c_mask[1], 64'h0000_0000_FFFF_FFFF);
    chk(1, "wr_no_rsp", 64'(h_rv[1]), 64'h0);

    // Out-of-range reads on both sides of the window.
    txn(64'h7FFF_FFF8, 0, 64'h0, 8'hFF);
    chk(0, "oor_lo_no_en", 64'(h_en[0]), 64'h0);
    chk(0, "oor_lo_rsp", 64'(h_rv[0]), 64'h10);
    chk(0, "oor_lo_data", c_data[0], 64'h0);
    txn(64'h1_0000_0000, 0, 64'h0, 8'hFF);
    chk(1, "oor_hi_no_en", 64'(h_en[1]), 64'h0);
    chk(1, "oor_hi_rsp", 64'(h_rv[1]), 64'h04);
    chk(1, "oor_hi_data", c_data[1], 64'h0);
    chk(0, "oor_err", 64'(err[0]), 64'd2);
    chk(1, "oor_err", 64'(err[1]), 64'd2);

    // Reset during the wait states of a write.
    wait_rdy();
    cmd_valid = 1; cmd_addr = 64'h8000_0020; cmd_wen = 1; cmd_wdata = 64'h55; cmd_wstrb = 8'hFF;
    @(posedge clk); #1;
    cmd_valid = 0;
    rst = 1;
    #1;
    for (int j = 0; j < 2; j++) begin
      chk(j, "rst_now_en", 64'(en[j]), 64'h0);
      chk(j, "rst_now_ready", 64'(rdy[j]), 64'h0);
      chk(j, "rst_now_wmask", wmask[j], 64'h0);
      chk(j, "rst_now_err", 64'(err[j]), 64'h0);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk(0, "rst_release_ready", 64'(rdy[0]), 64'h1);
    chk(1, "rst_release_ready", 64'(rdy[1]), 64'h1);
    txn(64'h8000_0018, 0, 64'h0, 8'hFF);
    chk(0, "post_rst_rsp", 64'(h_rv[0]), 64'h10);
    chk(0, "post_rst_idx", 64'(c_idx[0]), 64'd3);

    // Write with no byte enables.
    txn(64'h8000_0040, 1, 64'hFFFF, 8'h00);
    chk(0, "wstrb0_no_en", 64'(h_en[0]), 64'h0);
    chk(1, "wstrb0_no_en", 64'(h_en[1]), 64'h0);
    chk(0, "wstrb0_err", 64'(err[0]), 64'h0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      if (!rst && $urandom_range(0, 399) == 0) rst = 1;
      else if (rst && $urandom_range(0, 2) == 0) rst = 0;
      cmd_valid = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 6))
        0, 1, 2: cmd_addr = BASE + 64'($urandom_range(0, 32'h7FFF_FFFF));
        3:       cmd_addr = BASE - 64'($urandom_range(1, 64));
        4:       cmd_addr = BASE + 64'h8000_0000 + 64'($urandom_range(0, 64));
        5:       cmd_addr = BASE + 64'h7FFF_FFF8 + 64'($urandom_range(0, 7));
        default: cmd_addr = {$urandom, $urandom};
      endcase
      cmd_wen   = $urandom_range(0, 1) == 1;
      cmd_wstrb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      cmd_wdata = {$urandom, $urandom};
    end
    rst = 0; cmd_valid = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcache_responder.md
DCACHE_RESPONDER -- requirements
Module: dcache_responder

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 64'h8000_0000, the physical address mapped to RAM index 0.
REQ-002 The module SHALL have parameter WAIT_CYCLES, default 2, legal range 0..15, the number of idle wait states inserted before each RAM access.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  initiator presents a data-memory request.
REQ-006 cmd_ready  output  1  responder accepts a request when high.
REQ-007 cmd_payload_addr  input  64  byte address of the request.
REQ-008 cmd_payload_wen  input  1  1 = write, 0 = read.
REQ-009 cmd_payload_wdata  input  64  write data.
REQ-010 cmd_payload_wstrb  input  8  per-byte write enables.
REQ-011 rsp_valid  output  1  read data valid; single-cycle pulse; there is no back-pressure.
REQ-012 rsp_payload_data  output  64  read data.
REQ-013 ram_en  output  1  RAM access strobe.
REQ-014 ram_idx  output  28  64-bit word index, used for both read and write.
REQ-015 ram_wen  output  1  RAM write enable.
REQ-016 ram_wdata  output  64  RAM write data.
REQ-017 ram_wmask  output  64  RAM bit mask.
REQ-018 ram_rdata  input  64  RAM read data, valid the cycle after ram_en=1 with ram_wen=0.
REQ-019 err_count  output  16  count of out-of-range requests.

Function
REQ-020 The FSM SHALL have states IDLE, WAIT, ACCESS, READ and RESP.
REQ-021 cmd_ready SHALL be a register:
- set to 1 on the clock edge that enters IDLE;
- cleared on the accepting edge;
- 0 in every other state.
REQ-022 A handshake (cmd_valid and cmd_ready both 1 at an edge) SHALL latch addr, wen, wdata and wstrb, then move to WAIT if WAIT_CYCLES>0, else to ACCESS.
REQ-023 Payload changes after acceptance SHALL have no effect on the access in progress.
REQ-024 WAIT SHALL load a counter with WAIT_CYCLES-1, decrement it once per cycle, and move to ACCESS on the cycle the counter equals 0. WAIT therefore lasts exactly WAIT_CYCLES cycles.
REQ-025 Address offset off = addr - BASE_ADDR (64-bit, wrapping). ram_idx SHALL equal off[30:3].
REQ-026 A request SHALL be out-of-range when addr < BASE_ADDR or off[63:31] != 0.
REQ-027 In ACCESS with an in-range request, ram_en SHALL be 1 for exactly one cycle.
REQ-028 ACCESS write behaviour:
- ram_wen = 1;
- ram_wdata = latched wdata;
- ram_wmask byte i = {8{wstrb[i]}};
- next state IDLE;
- no response is generated.
REQ-029 A write with wstrb = 8'h00 SHALL NOT assert ram_en and SHALL return to IDLE.
REQ-030 ACCESS read behaviour: ram_wen = 0, ram_wmask = 0, next state READ.
REQ-031 READ SHALL register ram_rdata into rsp_payload_data, then move to RESP.
REQ-032 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-033 Read latency: rsp_valid SHALL be high during the (3+WAIT_CYCLES)th cycle after the accepting edge.
REQ-034 An out-of-range request SHALL NOT assert ram_en.
- Out-of-range read: rsp_payload_data = 64'h0, via READ and RESP, with the normal timing.
- Out-of-range write: dropped.
REQ-035 err_count SHALL increment by 1 in the ACCESS cycle of each out-of-range request and SHALL saturate at 16'hFFFF.
REQ-036 ram_en, ram_wen, ram_wmask and rsp_valid SHALL be 0 whenever they are not explicitly driven above.
REQ-037 rsp_payload_data SHALL hold its last value outside RESP.
REQ-038 Misaligned addresses (off[2:0] != 0) SHALL be accessed at word off[30:3]. The byte lanes are governed by wstrb only.

Reset
REQ-039 Asserting reset SHALL immediately force:
- state IDLE and the wait counter to 0;
- cmd_ready, rsp_valid, ram_en and ram_wen to 0;
- rsp_payload_data, ram_wmask and err_count to 0.
REQ-040 Reset asserted mid-operation SHALL abort the access with no RAM strobe and no response; the latched request is discarded.
REQ-041 cmd_ready SHALL become 1 on the first rising edge after reset deasserts.

Verification
REQ-042 Read, WAIT_CYCLES=2, addr 64'h8000_0010, ram_rdata=64'hDEAD_BEEF_0123_4567 -> ram_en pulse with ram_idx=2 and ram_wen=0; rsp_valid 5 cycles after accept; data matches; cmd_ready low until IDLE.
REQ-043 Write, WAIT_CYCLES=0, addr 64'h8000_0008, wstrb=8'h0F, wdata=64'h1122_3344_5566_7788 -> one-cycle ram_en/ram_wen with ram_idx=1 and ram_wmask=64'h0000_0000_FFFF_FFFF; rsp_valid never asserted.
REQ-044 Out-of-range reads at 64'h7FFF_FFF8 and 64'h1_0000_0000 -> no ram_en; rsp_valid with data 64'h0 each time; err_count ends at 2.
REQ-045 Back-to-back reads with cmd_valid held high -> second accept occurs on the edge entering IDLE after the first RESP; payload changes after accept do not alter ram_idx.
REQ-046 Reset asserted during WAIT of a write -> no ram_en, all outputs 0 immediately; cmd_ready=1 on first edge after release; a following read completes normally.
REQ-047 Write with wstrb=8'h00 -> no ram_en; returns to IDLE; err_count unchanged.
